// File: rtl/pool_pkg.sv
// Shared definitions for the pooling window controller and its compare unit.
package pool_pkg;

   // Controller state encoding
   typedef enum logic [1:0] {
      StIdle = 2'd0,
      StAcc  = 2'd1,
      StOut  = 2'd2
   } pool_state_e;

   // Compare-unit operation select
   localparam int unsigned MODE_MAX = 1;
   localparam int unsigned MODE_SUM = 0;

   // Ceiling log2, used to size the sample counter
   function automatic int unsigned clog2(input int unsigned value);
      int unsigned res;
      res = 0;
      for (int i = 0; i < 32; i++) begin
         if ((64'd1 << i) < 64'(value)) begin
            res = i + 1;
         end
      end
      return res;
   endfunction

endpackage

// File: rtl/pool_window_ctrl_cmp.sv
// Shared fixed-point compare/add unit: signed max (flag=MODE_MAX) or wrapping sum.
// Output is forced to zero while calculate_i is low so the datapath stays quiet.
module pool_window_ctrl_cmp
   import pool_pkg::*;
#(
   parameter int unsigned total_bits = 16,
   parameter int unsigned Q          = 12,
   parameter int unsigned flag       = MODE_MAX
) (
   input  logic [total_bits-1:0] a_i,
   input  logic [total_bits-1:0] b_i,
   input  logic                  calculate_i,
   output logic [total_bits-1:0] result_o
);

   // Q only labels the binary point; max and sum are identical for any Q
   if (Q >= total_bits) begin : g_bad_q
      $error("pool_window_ctrl_cmp: Q must be smaller than total_bits");
   end

   // Fold one operand pair when enabled
   always_comb begin
      result_o = '0;
      if (calculate_i) begin
         if (flag == MODE_MAX) begin
            result_o = ($signed(a_i) > $signed(b_i)) ? a_i : b_i;
         end else begin
            result_o = a_i + b_i;
         end
      end
   end

endmodule

// File: rtl/pool_window_ctrl.sv
// Pooling window sequencer: folds WIN samples via the shared compare unit and
// emits one registered result per window. Optional fused ReLU via POOL_RELU_EN.
module pool_window_ctrl
   import pool_pkg::*;
#(
   parameter int unsigned DATA_W = 16,
   parameter int unsigned Q      = 12,
   parameter int unsigned WIN    = 4,
   parameter int unsigned MODE   = MODE_MAX
) (
   input  logic              clk_i,
   input  logic              rst_i,
   input  logic              in_valid_i,
   output logic              in_ready_o,
   input  logic [DATA_W-1:0] in_data_i,
   input  logic              flush_i,
   output logic              out_valid_o,
   input  logic              out_ready_i,
   output logic [DATA_W-1:0] out_data_o,
   output logic              busy_o
);

   localparam int unsigned CntW = clog2(WIN + 1);
   localparam logic [CntW-1:0] CntLast = CntW'(WIN - 1);

   pool_state_e       state_q, state_d;
   logic [CntW-1:0]   cnt_q, cnt_d;
   logic [DATA_W-1:0] acc_q, acc_d;
   logic [DATA_W-1:0] out_data_q, out_data_d;
   logic              out_valid_q, out_valid_d;

   logic              calculate;
   logic              in_fire;
   logic [DATA_W-1:0] fold_res;
   logic [DATA_W-1:0] load_raw;
   logic [DATA_W-1:0] load_val;

   assign calculate = (state_q == StAcc);
   assign in_ready_o = ((state_q == StIdle) || (state_q == StAcc)) && !rst_i;
   assign in_fire = in_valid_i && in_ready_o;

   pool_window_ctrl_cmp #(
      .total_bits (DATA_W),
      .Q          (Q),
      .flag       (MODE)
   ) u_cmp (
      .a_i         (acc_q),
      .b_i         (in_data_i),
      .calculate_i (calculate),
      .result_o    (fold_res)
   );

   // Value loaded into the output register: first sample when WIN==1, else the fold
   assign load_raw = calculate ? fold_res : in_data_i;
`ifdef POOL_RELU_EN
   assign load_val = load_raw[DATA_W-1] ? '0 : load_raw;
`else
   assign load_val = load_raw;
`endif

   // Next-state logic for the window sequencer
   always_comb begin
      state_d     = state_q;
      cnt_d       = cnt_q;
      acc_d       = acc_q;
      out_data_d  = out_data_q;
      out_valid_d = out_valid_q;
      unique case (state_q)
         StIdle: begin
            if (flush_i) begin
               cnt_d = '0;
               acc_d = '0;
            end else if (in_fire) begin
               acc_d = in_data_i;
               cnt_d = CntW'(1);
               if (WIN == 1) begin
                  out_data_d  = load_val;
                  out_valid_d = 1'b1;
                  state_d     = StOut;
               end else begin
                  state_d = StAcc;
               end
            end
         end
         StAcc: begin
            if (flush_i) begin
               cnt_d   = '0;
               acc_d   = '0;
               state_d = StIdle;
            end else if (in_fire) begin
               acc_d = fold_res;
               cnt_d = cnt_q + CntW'(1);
               if (cnt_q == CntLast) begin
                  out_data_d  = load_val;
                  out_valid_d = 1'b1;
                  state_d     = StOut;
               end
            end
         end
         StOut: begin
            // Flush is ignored here; the pending result is always delivered
            if (out_ready_i) begin
               out_valid_d = 1'b0;
               cnt_d       = '0;
               state_d     = StIdle;
            end
         end
         default: begin
            state_d     = StIdle;
            cnt_d       = '0;
            acc_d       = '0;
            out_valid_d = 1'b0;
         end
      endcase
   end

   // State registers with synchronous reset
   always_ff @(posedge clk_i) begin
      if (rst_i) begin
         state_q     <= StIdle;
         cnt_q       <= '0;
         acc_q       <= '0;
         out_data_q  <= '0;
         out_valid_q <= 1'b0;
      end else begin
         state_q     <= state_d;
         cnt_q       <= cnt_d;
         acc_q       <= acc_d;
         out_data_q  <= out_data_d;
         out_valid_q <= out_valid_d;
      end
   end

   assign out_valid_o = out_valid_q;
   assign out_data_o  = out_data_q;
   assign busy_o      = (state_q != StIdle);

endmodule

// File: doc/pool_window_ctrl.md
Name: pool_window_ctrl

Overview:
- Sequencing controller for the shared fixed-point compare/add unit used in the pooling stage.
- Accepts a stream of Q-format samples over a valid/ready handshake and folds WIN consecutive samples into one result through the compare unit: running signed max (MODE=1) or running sum (MODE=0).
- Emits one registered result per window on a valid/ready output.
- Sits between the conv-output buffer and the pooled-feature writeback.

Parameters:
- DATA_W, 16, sample width, two's complement.
- Q, 12, fractional bits; passed through to the compare unit, no effect on control.
- WIN, 4, samples per window (2..64; 4 = 2x2 pool).
- MODE, 1, 1 = max pooling, 0 = sum pooling; drives the compare unit's flag.

Ports:
- clk  in  1  clock, all state updates on rising edge.
- rst  in  1  synchronous reset, active-high.
- in_valid  in  1  input sample valid.
- in_ready  out  1  controller can accept a sample.
- in_data  in  DATA_W  input sample.
- flush  in  1  abandon any partial window.
- out_valid  out  1  pooled result valid.
- out_ready  in  1  downstream accepts result.
- out_data  out  DATA_W  pooled result, registered.
- busy  out  1  high when state != IDLE.

Behaviour:
- Reset values:
  - state=IDLE, cnt=0, acc=0.
  - in_ready=0 during the reset cycle, 1 from the first cycle after rst deasserts.
  - out_valid=0, out_data=0, busy=0.
- FSM states: IDLE, ACC, OUT. A transfer occurs only when valid and ready are both high in the same cycle.
- IDLE:
  - in_ready=1.
  - On input transfer: acc<=in_data, cnt<=1.
  - Next state is ACC, or OUT if WIN==1.
- ACC:
  - in_ready=1.
  - On input transfer: acc<=op(acc,in_data), cnt<=cnt+1.
  - If cnt==WIN-1 at that transfer: out_data<=op(acc,in_data), out_valid<=1, next state OUT.
- OUT:
  - in_ready=0 and out_valid=1.
  - out_data is held stable until out_ready.
  - On output transfer: out_valid<=0, cnt<=0, next state IDLE.
- op() semantics:
  - Computed by the compare unit with calculate driven high only while state==ACC.
  - MODE=1: signed two's-complement max.
  - MODE=0: DATA_W-bit sum that wraps modulo 2^DATA_W, no saturation.
- Latency and throughput:
  - The result is valid on the cycle after the WIN-th input transfer.
  - Peak throughput is one window per WIN+1 cycles (the OUT cycle blocks input).
- cnt is clog2(WIN+1) bits wide and never exceeds WIN-1 while in ACC.
- flush:
  - In IDLE/ACC: acc, cnt and state are cleared to IDLE next cycle, and any input transfer in the same cycle is discarded.
  - In OUT: flush is ignored, and the pending result is still delivered.
- rst mid-window or mid-OUT: everything returns to reset values next cycle; the pending result is lost.
- in_valid held high while in_ready=0: no sample is consumed, and in_data may change freely.

Optional Feature:
- Macro POOL_RELU_EN.
- When defined, out_data is loaded as 0 whenever the folded result has its sign bit set (fused ReLU). The clamp applies to the registered value, so latency is unchanged.
- When undefined, the raw folded result is output.

Decomposition:
- Shared package pool_pkg holds:
  - state encoding (IDLE=2'd0, ACC=2'd1, OUT=2'd2);
  - MODE_MAX=1 and MODE_SUM=0 constants;
  - a cnt-width function clog2.
- One sub-module instance: the team's existing compare unit (total_bits=DATA_W, Q=Q, flag=MODE), inputs acc and in_data. The controller contains no arithmetic of its own.

Test Plan:
- MODE=1, WIN=4, inputs 0x1000, 0xF800, 0x2000, 0x0800 with in_valid constant -> out_valid on the cycle after the 4th sample, out_data=0x2000, busy low after out_ready.
- MODE=1, all negative 0xF800, 0xF000, 0xFC00, 0xE000 -> out_data=0xFC00; with POOL_RELU_EN -> 0x0000.
- MODE=0, inputs 0x1000, 0x1000, 0xF800, 0x0400 -> out_data=0x1C00; inputs 4x 0x7000 -> out_data=0xC000 (wrap).
- Backpressure: out_ready low for 5 cycles after out_valid -> out_data stable, in_ready=0 throughout, no sample consumed; the next window starts after release.
- flush after 2 samples (0x3000, 0x1000), then 0x0100, 0x0200, 0x0300, 0x0400 -> out_data=0x0400, with the earlier samples excluded.
- rst asserted in the OUT state and mid-ACC -> next cycle out_valid=0, out_data=0, busy=0; the following window computes correctly from scratch.
